imm_encode: RTL
===============

// Module: imm_encode
// PURPOSE
//  Dual-lane immediate encoder: inverse of the decode-stage immediate extender. Takes a
//  32-bit instruction template plus a 32-bit immediate per lane and inserts the immediate
//  into the I/S/B/U/J bit positions. Used by the program loader / self-test generator to
//  build instruction pairs. Two-stage valid/ready pipeline; flags immediates not encodable.
// PARAMETERS
//  DATA_WIDTH  32  instruction/immediate width (only 32 supported)
//  CNT_WIDTH   16  width of the encoded-pair and error counters
// PORTS
//  clk          in   1           rising-edge clock
//  rst_n        in   1           asynchronous, active-low reset
//  in_valid     in   1           input pair valid
//  in_ready     out  1           encoder accepts the pair this cycle
//  ImmSrc       in   6           [5:3] lane A type, [2:0] lane B type: 000 I,001 S,010 B,011 U,100 J
//  tmplA/tmplB  in   DATA_WIDTH  instruction template (opcode/rd/rs/funct bits) per lane
//  immA/immB    in   DATA_WIDTH  immediate value per lane (already sign-extended)
//  out_valid    out  1           encoded pair valid
//  out_ready    in   1           downstream accepts the pair
//  instrA/instrB out DATA_WIDTH  encoded instruction per lane
//  errA/errB    out  1           immediate not representable for selected type
//  pair_cnt     out  CNT_WIDTH   pairs delivered (out_valid&&out_ready), saturating
//  err_cnt      out  CNT_WIDTH   delivered pairs with errA|errB set, saturating
// BEHAVIOUR
//  - Reset (async assert, sync release): s1_valid=s2_valid=0, out_valid=0, instrA/B=0,
//    errA/B=0, pair_cnt=err_cnt=0. in_ready=1 in the first cycle after release.
//  - Handshake: transfer when valid&&ready; a valid, once high, holds with stable data until
//    accepted. Output data is held stable while out_valid&&!out_ready.
//  - Stage 1 registers ImmSrc/tmpl/imm; stage 2 registers encoded words and error flags.
//    adv2 = !s2_valid||out_ready; adv1 = !s1_valid||adv2; in_ready = adv1.
//    Latency 2 cycles accept->out_valid; throughput 1 pair/cycle with out_ready=1.
//  - Encoding (template bits outside the field are kept):
//    I: [31:20]=imm[11:0]. S: [31:25]=imm[11:5], [11:7]=imm[4:0].
//    B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1].
//    U: [31:12]=imm[31:12]. J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
//    Codes 101-111: instr = template unchanged.
//  - Range check: I/S need imm[31:11] all equal; B needs imm[31:12] all equal and imm[0]=0;
//    U needs imm[11:0]=0; J needs imm[31:20] all equal and imm[0]=0; codes 101-111 -> err=1.
//    On error the truncated encoding is still emitted.
//  - Counters increment only on output transfer; both saturate at all-ones, no wrap.
//  - Simultaneous accept and deliver: both stages advance in the same cycle, no bubble.
//  - Reset mid-operation: in-flight pairs are discarded, counters cleared.
// CONFIGURATION
//  IMM_RANGE_CHECK_EN defined: range check as above; errA/errB and err_cnt live.
//  Not defined: no check logic; errA=errB=0 and err_cnt=0 constantly; encoding unchanged.
// TESTING
//  1. ImmSrc=000_000, tmplA=0x00000013, immA=0xFFFFFFFF -> instrA=0xFFF00013, errA=0, 2 cycles later.
//  2. Lane B S-type, tmplB=0x00002023, immB=0x00000804 -> instrB=0x00002223? no: imm out of range -> errB=1 (check on).
//  3. B-type tmplA=0x00000063, immA=0xFFFFFFF8 -> instrA=0xFE000CE3, errA=0; immA=0x3 -> errA=1.
//  4. U-type immA=0x12345000 on tmpl 0x00000037 -> 0x12345037; J immA=0x00000800, tmpl 0x6F -> 0x0010006F.
//  5. Stream 8 pairs, out_ready held 0 for 3 cycles mid-burst -> in_ready drops, no loss/dup, pair_cnt=8.
//  6. Assert rst_n low with both stages full -> out_valid=0 immediately, counters 0, in_ready=1 after release.

Source files
------------

// File: rtl/imm_encode.sv
// imm_encode: dual-lane I/S/B/U/J immediate inserter with a two-stage valid/ready pipeline.
// Define IMM_RANGE_CHECK_EN to flag immediates that the selected format cannot represent.
module imm_encode #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            ImmSrc,
  input  logic [DATA_WIDTH-1:0] tmplA,
  input  logic [DATA_WIDTH-1:0] tmplB,
  input  logic [DATA_WIDTH-1:0] immA,
  input  logic [DATA_WIDTH-1:0] immB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] instrA,
  output logic [DATA_WIDTH-1:0] instrB,
  output logic                  errA,
  output logic                  errB,
  output logic [CNT_WIDTH-1:0]  pair_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt
);
  function automatic logic [31:0] enc(input logic [2:0] t, input logic [31:0] tm, input logic [31:0] im);
    logic [31:0] r;
    r = tm;
    case (t)
      3'd0: r[31:20] = im[11:0];
      3'd1: begin
        r[31:25] = im[11:5];
        r[11:7]  = im[4:0];
      end
      3'd2: begin
        r[31]    = im[12];
        r[7]     = im[11];
        r[30:25] = im[10:5];
        r[11:8]  = im[4:1];
      end
      3'd3: r[31:12] = im[31:12];
      3'd4: begin
        r[31]    = im[20];
        r[30:21] = im[10:1];
        r[20]    = im[11];
        r[19:12] = im[19:12];
      end
      default: ;
    endcase
    return r;
  endfunction

  logic                  s1_valid_q, s2_valid_q;
  logic [5:0]            s1_src_q;
  logic [DATA_WIDTH-1:0] s1_tmpl_a_q, s1_tmpl_b_q, s1_imm_a_q, s1_imm_b_q;
  logic [DATA_WIDTH-1:0] instr_a_q, instr_b_q, instr_a_d, instr_b_d;
  logic [CNT_WIDTH-1:0]  pair_cnt_q;
  logic                  adv1, adv2, deliver;

  assign adv2      = !s2_valid_q || out_ready;
  assign adv1      = !s1_valid_q || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid_q;
  assign deliver   = s2_valid_q && out_ready;
  assign instrA    = instr_a_q;
  assign instrB    = instr_b_q;
  assign pair_cnt  = pair_cnt_q;
  assign instr_a_d = enc(s1_src_q[5:3], s1_tmpl_a_q, s1_imm_a_q);
  assign instr_b_d = enc(s1_src_q[2:0], s1_tmpl_b_q, s1_imm_b_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_src_q    <= '0;
      s1_tmpl_a_q <= '0;
      s1_tmpl_b_q <= '0;
      s1_imm_a_q  <= '0;
      s1_imm_b_q  <= '0;
    end else if (adv1) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_src_q    <= ImmSrc;
        s1_tmpl_a_q <= tmplA;
        s1_tmpl_b_q <= tmplB;
        s1_imm_a_q  <= immA;
        s1_imm_b_q  <= immB;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      instr_a_q  <= '0;
      instr_b_q  <= '0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        instr_a_q <= instr_a_d;
        instr_b_q <= instr_b_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pair_cnt_q <= '0;
    else if (deliver && !(&pair_cnt_q)) pair_cnt_q <= pair_cnt_q + CNT_WIDTH'(1);
  end

`ifdef IMM_RANGE_CHECK_EN
  // Truncated encodings are still emitted; only the flag reports the overflow.
  function automatic logic bad(input logic [2:0] t, input logic [31:0] im);
    case (t)
      3'd0, 3'd1: return !(&im[31:11] || ~|im[31:11]);
      3'd2:       return !(&im[31:12] || ~|im[31:12]) || im[0];
      3'd3:       return |im[11:0];
      3'd4:       return !(&im[31:20] || ~|im[31:20]) || im[0];
      default:    return 1'b1;
    endcase
  endfunction

  logic                 err_a_q, err_b_q, err_a_d, err_b_d;
  logic [CNT_WIDTH-1:0] err_cnt_q;

  assign err_a_d = bad(s1_src_q[5:3], s1_imm_a_q);
  assign err_b_d = bad(s1_src_q[2:0], s1_imm_b_q);
  assign errA    = err_a_q;
  assign errB    = err_b_q;
  assign err_cnt = err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_a_q <= 1'b0;
      err_b_q <= 1'b0;
    end else if (adv2 && s1_valid_q) begin
      err_a_q <= err_a_d;
      err_b_q <= err_b_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else if (deliver && (err_a_q || err_b_q) && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
  end
`else
  assign errA    = 1'b0;
  assign errB    = 1'b0;
  assign err_cnt = '0;
`endif
endmodule
